// File: rtl/screen_pkg.sv
// Mode encodings shared by the screen sequencer and the VGA screen-select mux.
package screen_pkg;

  localparam logic [2:0] MODE_TITLE = 3'b000;
  localparam logic [2:0] MODE_GAME  = 3'b001;
  localparam logic [2:0] MODE_INBET = 3'b010;
  localparam logic [2:0] MODE_WIN   = 3'b011;
  localparam logic [2:0] MODE_GOVER = 3'b100;

  // Bits needed to hold the larger of two frame counts without wrapping.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter with synchronous clear and a terminal-count compare.
module frame_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  // Saturates rather than wraps; the owner clears it on every screen entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = en && (count == term);

endmodule

// File: rtl/screen_mode_ctrl.sv
// Game-flow screen sequencer; screen changes commit only on frame_tick.
// Optional build macro SCREEN_AUTO_RETURN_EN: WIN/GOVER return to TITLE after END_FRAMES frames.
module screen_mode_ctrl
  import screen_pkg::*;
#(
  parameter int INBET_FRAMES = 120,
  parameter int END_FRAMES   = 300,
  parameter int MAX_LEVEL    = 5,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       wave_clear,
  input  logic       player_hit,
  output logic [2:0] mode,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic       game_run,
  output logic       level_load,
  output logic       score_clr
);

  localparam int CW = timer_width(INBET_FRAMES, END_FRAMES);

  logic          pend_valid, pend_valid_n;
  logic [2:0]    pend_mode, pend_mode_n;
  logic          start_q;
  logic          start_rise;
  logic [2:0]    mode_n, level_n;
  logic [1:0]    lives_n;
  logic          load_n, clr_n;
  logic          commit;
  logic          timer_clr, timer_en, timer_done;
  logic [CW-1:0] timer_term, timer_count;

  assign start_rise = start_btn & ~start_q;
  assign commit     = pend_valid & frame_tick;

`ifdef SCREEN_AUTO_RETURN_EN
  assign timer_en = frame_tick &&
                    ((mode == MODE_INBET) || (mode == MODE_WIN) || (mode == MODE_GOVER));
`else
  assign timer_en = frame_tick && (mode == MODE_INBET);
`endif
  assign timer_term = (mode == MODE_INBET) ? CW'(INBET_FRAMES - 1) : CW'(END_FRAMES - 1);
  assign timer_clr  = (mode_n != mode);

  frame_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .term    (timer_term),
    .count   (timer_count),
    .at_term (timer_done)
  );

  always_comb begin
    mode_n       = mode;
    level_n      = level;
    lives_n      = lives;
    pend_valid_n = pend_valid;
    pend_mode_n  = pend_mode;
    load_n       = 1'b0;
    clr_n        = 1'b0;

    // Only the registered request commits, so an event on the tick waits a frame.
    if (commit) begin
      mode_n       = pend_mode;
      pend_valid_n = 1'b0;
      if (pend_mode == MODE_GAME) begin
        level_n = 3'd1;
        lives_n = 2'(LIVES);
        load_n  = 1'b1;
        clr_n   = 1'b1;
      end
    end

    case (mode)
      MODE_TITLE: begin
        if (!pend_valid && start_rise) begin
          pend_valid_n = 1'b1;
          pend_mode_n  = MODE_GAME;
        end
      end
      MODE_GAME: begin
        if (!pend_valid) begin
          if (player_hit && (lives <= 2'd1)) begin
            lives_n      = 2'd0;
            pend_valid_n = 1'b1;
            pend_mode_n  = MODE_GOVER;
          end else begin
            if (player_hit) lives_n = lives - 2'd1;
            if (wave_clear) begin
              pend_valid_n = 1'b1;
              pend_mode_n  = (level == 3'(MAX_LEVEL)) ? MODE_WIN : MODE_INBET;
            end
          end
        end
      end
      MODE_INBET: begin
        if (timer_done) begin
          mode_n  = MODE_GAME;
          level_n = level + 3'd1;
          load_n  = 1'b1;
        end
      end
      MODE_WIN, MODE_GOVER: begin
        if (!pend_valid && start_rise) begin
          pend_valid_n = 1'b1;
          pend_mode_n  = MODE_TITLE;
        end
`ifdef SCREEN_AUTO_RETURN_EN
        if (timer_done) begin
          mode_n       = MODE_TITLE;
          pend_valid_n = 1'b0;
        end
`endif
      end
      default: begin
        mode_n       = MODE_TITLE;
        pend_valid_n = 1'b0;
        load_n       = 1'b0;
        clr_n        = 1'b0;
      end
    endcase
  end

  // Start history resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MODE_TITLE;
      level      <= 3'd1;
      lives      <= 2'(LIVES);
      pend_valid <= 1'b0;
      pend_mode  <= MODE_TITLE;
      start_q    <= 1'b1;
      game_run   <= 1'b0;
      level_load <= 1'b0;
      score_clr  <= 1'b0;
    end else begin
      mode       <= mode_n;
      level      <= level_n;
      lives      <= lives_n;
      pend_valid <= pend_valid_n;
      pend_mode  <= pend_mode_n;
      start_q    <= start_btn;
      game_run   <= (mode_n == MODE_GAME) && !pend_valid_n;
      level_load <= load_n;
      score_clr  <= clr_n;
    end
  end

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Scoreboard bench for screen_mode_ctrl: directed vectors queue expected outputs per cycle.
module tb_screen_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, start_btn, wave_clear, player_hit;
  logic [2:0] mode, level;
  logic [1:0] lives;
  logic       game_run, level_load, score_clr;

  screen_mode_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .wave_clear (wave_clear),
    .player_hit (player_hit),
    .mode       (mode),
    .level      (level),
    .lives      (lives),
    .game_run   (game_run),
    .level_load (level_load),
    .score_clr  (score_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t        e;
      logic [10:0] act;
      e   = sb_q.pop_front();
      act = {mode, level, lives, game_run, level_load, score_clr};
      total++;
      if (e.cyc == cyc && act === e.exp) begin
        passed++;
      end else begin
        $display("[TB] FAIL %s: got %b required %b (mode,level,lives,run,load,clr) cycle %0d/%0d",
                 e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic expect_now(input string name, input logic [2:0] m, input logic [2:0] l,
                            input logic [1:0] v, input logic r, input logic ll, input logic sc);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.exp  = {m, l, v, r, ll, sc};
    sb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic ft, input logic sb, input logic wc, input logic ph);
    frame_tick = ft;
    start_btn  = sb;
    wave_clear = wc;
    player_hit = ph;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    wave_clear = 1'b0;
    player_hit = 1'b0;
  endtask

  task automatic do_intermission(input logic [2:0] from_lvl, input logic [1:0] lf);
    logic [2:0] nxt;
    nxt = from_lvl + 3'd1;
    apply_stimulus(0, 0, 1, 0);
    expect_now("inbet_request", 3'd1, from_lvl, lf, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("inbet_enter", 3'd2, from_lvl, lf, 0, 0, 0);
    for (int i = 0; i < 119; i++) apply_stimulus(1, 0, 0, 0);
    expect_now("inbet_hold", 3'd2, from_lvl, lf, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("inbet_exit", 3'd1, nxt, lf, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0);
    expect_now("inbet_load_end", 3'd1, nxt, lf, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b1; wave_clear = 1'b0; player_hit = 1'b0;
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    expect_now("reset", 3'd0, 3'd1, 2'd3, 0, 0, 0);

    // Button held through reset release must not start a game.
    rst = 1'b0;
    apply_stimulus(1, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    expect_now("btn_held", 3'd0, 3'd1, 2'd3, 0, 0, 0);

    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    expect_now("start_pending", 3'd0, 3'd1, 2'd3, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    expect_now("game_entry", 3'd1, 3'd1, 2'd3, 1, 1, 1);
    apply_stimulus(0, 1, 0, 0);
    expect_now("entry_pulse_end", 3'd1, 3'd1, 2'd3, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0);

    do_intermission(3'd1, 2'd3);
    do_intermission(3'd2, 2'd3);
    do_intermission(3'd3, 2'd3);
    do_intermission(3'd4, 2'd3);

    apply_stimulus(0, 0, 0, 1);
    expect_now("hit", 3'd1, 3'd5, 2'd2, 1, 0, 0);

    // Clear on the frame boundary commits one frame later.
    apply_stimulus(1, 0, 1, 0);
    expect_now("edge_clear", 3'd1, 3'd5, 2'd2, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    expect_now("hit_ignored", 3'd1, 3'd5, 2'd2, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("win", 3'd3, 3'd5, 2'd2, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("win_hold", 3'd3, 3'd5, 2'd2, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    expect_now("title_back", 3'd0, 3'd5, 2'd2, 0, 0, 0);

    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    expect_now("restart", 3'd1, 3'd1, 2'd3, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1);
    expect_now("lives_one", 3'd1, 3'd1, 2'd1, 1, 0, 0);
    apply_stimulus(0, 0, 1, 1);
    expect_now("last_life", 3'd1, 3'd1, 2'd0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("gover", 3'd4, 3'd1, 2'd0, 0, 0, 0);

`ifdef SCREEN_AUTO_RETURN_EN
    for (int i = 0; i < 299; i++) apply_stimulus(1, 0, 0, 0);
    expect_now("gover_hold", 3'd4, 3'd1, 2'd0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    expect_now("auto_return", 3'd0, 3'd1, 2'd0, 0, 0, 0);
`else
    for (int i = 0; i < 1000; i++) apply_stimulus(1, 0, 0, 0);
    expect_now("gover_hold", 3'd4, 3'd1, 2'd0, 0, 0, 0);
`endif

    // Reset on a committing tick overrides the pending request.
    apply_stimulus(0, 1, 0, 0);
    rst = 1'b1;
    apply_stimulus(1, 1, 0, 0);
    expect_now("mid_reset", 3'd0, 3'd1, 2'd3, 0, 0, 0);
    rst = 1'b0;
    apply_stimulus(1, 1, 0, 0);
    expect_now("post_reset", 3'd0, 3'd1, 2'd3, 0, 0, 0);

    repeat (3) apply_stimulus(0, 0, 0, 0);
    if (sb_q.size() != 0) begin
      total++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
